// File: rtl/consumer_buffer.sv
// consumer_buffer: per-channel input FIFOs drained onto one output by a round-robin arbiter
module consumer_buffer #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     stall,
  output logic [NUM_CH*DATA_W-1:0] hold_data,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*CNT_W-1:0]  accept_cnt,
  output logic [NUM_CH-1:0]        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;
  logic [CH_W-1:0] grant, last_grant, nxt, base;
  logic found, take, advance;
  logic [NUM_CH-1:0] push, pop, avail, near_full;
  logic [NUM_CH-1:0][CW-1:0] count;
  logic [NUM_CH-1:0][AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [AW-1:0] head_ptr;
  int j;
  assign take = (state == OFFER) && out_ready;
  assign advance = (state == IDLE) || out_ready;
  assign base = (state == OFFER) ? grant : last_grant;
  assign stall = |near_full;
  assign head_ptr = rd_ptr[nxt] + AW'(take && nxt == grant);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign in_ready[g] = count[g] < CW'(DEPTH);
    assign near_full[g] = count[g] >= CW'(DEPTH - 1);
    assign push[g] = in_valid[g] && in_ready[g];
    assign pop[g] = take && grant == CH_W'(g);
    assign avail[g] = pop[g] ? (count[g] > CW'(1)) : (count[g] != '0);
    // occupancy, pointers, last-accepted word, accept counter and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count[g] <= '0;
        wr_ptr[g] <= '0;
        rd_ptr[g] <= '0;
        hold_data[g*DATA_W +: DATA_W] <= '0;
        accept_cnt[g*CNT_W +: CNT_W] <= '0;
        overflow[g] <= 1'b0;
      end else begin
        count[g] <= count[g] + CW'(push[g]) - CW'(pop[g]);
        if (push[g]) begin
          wr_ptr[g] <= wr_ptr[g] + 1'b1;
          hold_data[g*DATA_W +: DATA_W] <= in_data[g*DATA_W +: DATA_W];
          accept_cnt[g*CNT_W +: CNT_W] <= accept_cnt[g*CNT_W +: CNT_W] + 1'b1;
        end
        if (pop[g]) rd_ptr[g] <= rd_ptr[g] + 1'b1;
        if (in_valid[g] && !in_ready[g]) overflow[g] <= 1'b1;
      end
    end
    // FIFO storage is left uncleared by reset; the pointers alone define contents
    always_ff @(posedge clk)
      if (push[g]) mem[g][wr_ptr[g]] <= in_data[g*DATA_W +: DATA_W];
  end
  // round-robin scan: nearest non-empty channel after base, using post-pop occupancy
  always_comb begin
    found = 1'b0;
    nxt = '0;
    j = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      j = (int'(base) + k) % NUM_CH;
      if (avail[j[CH_W-1:0]]) begin
        found = 1'b1;
        nxt = j[CH_W-1:0];
      end
    end
  end
  // arbiter FSM; outputs are registered with the head word of the next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
    end else if (advance) begin
      if (state == OFFER) last_grant <= grant;
      state <= found ? OFFER : IDLE;
      if (found) grant <= nxt;
      out_valid <= found;
      out_ch <= found ? nxt : '0;
      out_data <= found ? mem[nxt][head_ptr] : '0;
    end
  end
endmodule
